kbd_decode: RTL and testbench
=============================

# kbd_decode

Scancode decoder between the PS/2 byte receiver and the `kbdrom` lookup ROM. It accepts set-2 scancode bytes and tracks the break (0xF0) and extended (0xE0) prefixes, the Shift state and the Caps Lock toggle. For each make code it runs one ROM lookup and selects the unshifted or shifted character from the ROM word. It presents the resulting 7-bit ASCII to the VGA text writer on a valid/ready handshake.

## Interface
Parameters:
- SC_LSHIFT, 8'h12, left Shift scancode
- SC_RSHIFT, 8'h59, right Shift scancode
- SC_CAPS, 8'h58, Caps Lock scancode

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately
- sc_data  in  8  scancode byte from PS/2 receiver
- sc_valid  in  1  one-cycle strobe, sc_data valid
- sc_ready  out  1  high only in IDLE; byte accepted when sc_valid & sc_ready
- rom_ad  out  7  ROM address, registered
- rom_ce  out  1  ROM read enable, one-cycle pulse per lookup
- rom_dout  in  14  ROM word: [6:0] unshifted char, [13:7] shifted char; 0 = unmapped
- key_ascii  out  7  decoded character
- key_valid  out  1  character available; held until accepted
- key_ready  in  1  downstream accepts when key_valid & key_ready
- shift_st  out  1  current Shift state (either Shift key held)
- caps_st  out  1  current Caps Lock state
- ovr  out  1  one-cycle pulse: byte arrived while sc_ready=0 and was dropped

## Operation
- States: IDLE, LOOKUP, CAPTURE, OUT.
- IDLE, on acceptance of byte b:
  - b=0xE0: set ext; stay IDLE.
  - b=0xF0: set brk; stay IDLE.
  - b=SC_LSHIFT or SC_RSHIFT: the matching Shift bit is cleared if brk, else set. Clear ext and brk. Stay IDLE.
  - b=SC_CAPS: toggle caps_st if brk=0, ignore if brk=1. Clear ext and brk. Stay IDLE.
  - brk=1 or ext=1, or b[7]=1: discard. Clear ext and brk. Stay IDLE.
  - Otherwise: register rom_ad=b[6:0], clear flags, go to LOOKUP.
- LOOKUP: rom_ce=1 for this cycle only; go to CAPTURE.
- CAPTURE:
  - u=rom_dout[6:0], s=rom_dout[13:7].
  - sel = shift_st XOR (caps_st AND 7'h61<=u<=7'h7A).
  - c = sel ? s : u.
  - c=0: go to IDLE, no output. Else register key_ascii=c and go to OUT.
- OUT: key_valid=1. key_ascii is stable until the handshake completes. Go to IDLE on the cycle key_valid & key_ready.
- shift_st = left Shift bit OR right Shift bit.
- Shift and Caps updates are taken only in IDLE, so they never alter a lookup already in flight.
- sc_valid while sc_ready=0: byte dropped; ovr=1 on the following cycle; no state change.

## Timing
- Reset values:
  - state=IDLE, so sc_ready=1.
  - rom_ad=0, rom_ce=0, key_ascii=0, key_valid=0.
  - shift_st=0, caps_st=0, ovr=0; ext and brk cleared.
- Byte accepted at cycle N:
  - N+1: rom_ce=1 with rom_ad valid.
  - N+2: CAPTURE samples rom_dout (ROM has one-cycle registered latency).
  - N+3: key_valid=1.
- key_ready already high at N+3: IDLE at N+4, sc_ready=1 at N+4. Minimum spacing between accepted make codes is 4 cycles.
- Prefix, modifier and discarded bytes: processed in the acceptance cycle; sc_ready stays 1, so back-to-back bytes are allowed.
- Reset mid-lookup or during OUT: key_valid drops asynchronously; the pending character is lost; rom_ce=0.
- rom_ce=0 in every state except LOOKUP, so rom_dout holds its value between lookups.

## Structure
- Shared package kbd_pkg holds:
  - scancode constants 0xE0, 0xF0, 0x12, 0x59, 0x58;
  - the state enumeration;
  - the ASCII 'a'/'z' bounds.
- One sub-module, kbd_char_sel: combinational u/s/shift/caps to c selection. It is reused by the bench reference model.
- The kbdrom instance is external, wired by the parent.

## Test plan
- ROM[0x1C]={7'h41,7'h61}. Send 0x1C, key_ready=1 → rom_ce at N+1 with rom_ad=0x1C; key_valid at N+3 with key_ascii=0x61. Send F0,1C → no output.
- Send 12, then 1C → 0x41. Send F0,12, then 1C → 0x61. shift_st follows.
- Send 58, F0,58 → caps_st=1. Then 1C → 0x41. With ROM[0x16]={7'h21,7'h31}, send 16 → 0x31, because Caps does not affect digits.
- Caps on and Shift held, send 1C → 0x61. Send E0,75 → no lookup, rom_ce stays 0. Send 0x83 → discarded.
- Hold key_ready=0 for 10 cycles after key_valid → key_ascii stable, sc_ready=0; a byte sent meanwhile gives an ovr pulse. Release → IDLE next cycle.
- Assert reset during LOOKUP → key_valid=0, sc_ready=1, shift_st=0, caps_st=0 immediately. Next 1C after release → 0x61.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared constants and the FSM state type for the set-2 scancode decoder.
package kbd_pkg;

    // Prefix and modifier scancodes (PS/2 set 2)
    localparam logic [7:0] KBD_SC_EXT    = 8'hE0;
    localparam logic [7:0] KBD_SC_BRK    = 8'hF0;
    localparam logic [7:0] KBD_SC_LSHIFT = 8'h12;
    localparam logic [7:0] KBD_SC_RSHIFT = 8'h59;
    localparam logic [7:0] KBD_SC_CAPS   = 8'h58;

    // Lowercase letter bounds; Caps Lock only affects characters in this range
    localparam logic [6:0] KBD_ASCII_LOWER_A = 7'h61;
    localparam logic [6:0] KBD_ASCII_LOWER_Z = 7'h7A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_OUT     = 2'd3
    } kbd_state_t;

endpackage

// File: rtl/kbd_char_sel.sv
// Picks the unshifted or shifted character of a ROM word from the current
// Shift and Caps Lock state. Caps Lock inverts the Shift sense only for letters.
module kbd_char_sel
    import kbd_pkg::*;
(
    input  logic [6:0] u,
    input  logic [6:0] s,
    input  logic       shift,
    input  logic       caps,
    output logic [6:0] c
);

    logic is_letter;
    logic sel;

    // Letter test on the unshifted character, then the Shift/Caps selection
    always_comb begin
        is_letter = (u >= KBD_ASCII_LOWER_A) && (u <= KBD_ASCII_LOWER_Z);
        sel       = shift ^ (caps & is_letter);
        c         = sel ? s : u;
    end

endmodule

// File: rtl/kbd_decode.sv
// Scancode decoder: tracks break/extended prefixes and Shift/Caps state,
// performs one ROM lookup per make code and hands the character downstream.
module kbd_decode
    import kbd_pkg::*;
#(
    parameter logic [7:0] SC_LSHIFT = KBD_SC_LSHIFT,
    parameter logic [7:0] SC_RSHIFT = KBD_SC_RSHIFT,
    parameter logic [7:0] SC_CAPS   = KBD_SC_CAPS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  sc_data,
    input  logic        sc_valid,
    output logic        sc_ready,
    output logic [6:0]  rom_ad,
    output logic        rom_ce,
    input  logic [13:0] rom_dout,
    output logic [6:0]  key_ascii,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        shift_st,
    output logic        caps_st,
    output logic        ovr
);

    kbd_state_t state_q, state_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       lshift_q, lshift_d;
    logic       rshift_q, rshift_d;
    logic       caps_q, caps_d;
    logic [6:0] rom_ad_q, rom_ad_d;
    logic [6:0] key_ascii_q, key_ascii_d;
    logic       ovr_q, ovr_d;
    logic [6:0] char_c;

    kbd_char_sel u_char_sel (
        .u     (rom_dout[6:0]),
        .s     (rom_dout[13:7]),
        .shift (lshift_q | rshift_q),
        .caps  (caps_q),
        .c     (char_c)
    );

    // Next-state logic: byte classification in IDLE, then the lookup pipeline
    always_comb begin
        state_d     = state_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_d      = caps_q;
        rom_ad_d    = rom_ad_q;
        key_ascii_d = key_ascii_q;
        ovr_d       = sc_valid && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (sc_valid) begin
                    if (sc_data == KBD_SC_EXT) begin
                        ext_d = 1'b1;
                    end else if (sc_data == KBD_SC_BRK) begin
                        brk_d = 1'b1;
                    end else begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                        if (sc_data == SC_LSHIFT) begin
                            lshift_d = ~brk_q;
                        end else if (sc_data == SC_RSHIFT) begin
                            rshift_d = ~brk_q;
                        end else if (sc_data == SC_CAPS) begin
                            if (!brk_q) begin
                                caps_d = ~caps_q;
                            end
                        end else if (!(brk_q || ext_q || sc_data[7])) begin
                            rom_ad_d = sc_data[6:0];
                            state_d  = ST_LOOKUP;
                        end
                    end
                end
            end
            ST_LOOKUP: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (char_c != 7'd0) begin
                    key_ascii_d = char_c;
                    state_d     = ST_OUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (key_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_q      <= 1'b0;
            rom_ad_q    <= 7'd0;
            key_ascii_q <= 7'd0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_q      <= caps_d;
            rom_ad_q    <= rom_ad_d;
            key_ascii_q <= key_ascii_d;
            ovr_q       <= ovr_d;
        end
    end

    assign sc_ready  = (state_q == ST_IDLE);
    assign rom_ce    = (state_q == ST_LOOKUP);
    assign key_valid = (state_q == ST_OUT);
    assign rom_ad    = rom_ad_q;
    assign key_ascii = key_ascii_q;
    assign shift_st  = lshift_q | rshift_q;
    assign caps_st   = caps_q;
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_kbd_decode.sv
// Self-checking bench for kbd_decode: directed test-plan steps followed by
// random scancode traffic, all compared against a behavioural keyboard model.
module tb_kbd_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  sc_data = 8'd0;
    logic        sc_valid = 1'b0;
    logic        sc_ready;
    logic [6:0]  rom_ad;
    logic        rom_ce;
    logic [13:0] rom_dout = 14'd0;
    logic [6:0]  key_ascii;
    logic        key_valid;
    logic        key_ready = 1'b1;
    logic        shift_st;
    logic        caps_st;
    logic        ovr;

    int checks = 0;
    int failures = 0;

    // Behavioural keyboard state
    bit m_ext, m_brk, m_lshift, m_rshift, m_caps;
    logic [13:0] rom_mem [128];

    kbd_decode dut (
        .clk       (clk),
        .reset     (reset),
        .sc_data   (sc_data),
        .sc_valid  (sc_valid),
        .sc_ready  (sc_ready),
        .rom_ad    (rom_ad),
        .rom_ce    (rom_ce),
        .rom_dout  (rom_dout),
        .key_ascii (key_ascii),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .shift_st  (shift_st),
        .caps_st   (caps_st),
        .ovr       (ovr)
    );

    always #5 clk = ~clk;

    // External ROM with one cycle of registered read latency
    always @(posedge clk) begin
        if (rom_ce) rom_dout <= rom_mem[rom_ad];
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_ext = 0; m_brk = 0; m_lshift = 0; m_rshift = 0; m_caps = 0;
    endtask

    // Apply keyboard rules to one accepted byte; report whether a lookup happens
    // and which character (0 = none) should appear.
    task automatic modelByte(input logic [7:0] b, output bit lookup, output logic [6:0] expc);
        int u, s;
        bit letter, use_shifted;
        lookup = 0;
        expc = 7'd0;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (b == 8'h12) m_lshift = !m_brk;
            else if (b == 8'h59) m_rshift = !m_brk;
            else if (b == 8'h58) begin
                if (!m_brk) m_caps = !m_caps;
            end else if (!(m_brk || m_ext || b >= 8'h80)) begin
                lookup = 1;
                u = int'(rom_mem[b[6:0]]) % 128;
                s = int'(rom_mem[b[6:0]]) / 128;
                letter = (u >= 97) && (u <= 122);
                use_shifted = (m_lshift || m_rshift) != (m_caps && letter);
                expc = use_shifted ? 7'(s) : 7'(u);
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // Send one byte from IDLE and follow it through the whole decode; when hold
    // is non-zero the downstream stalls that many cycles, and a stall of four or
    // more also injects a byte that must be dropped with an overrun pulse.
    task automatic applyStimulus(input logic [7:0] b, input int hold);
        bit lookup;
        logic [6:0] expc;
        modelByte(b, lookup, expc);
        key_ready = (hold == 0);
        @(negedge clk);
        sc_data = b;
        sc_valid = 1'b1;
        @(negedge clk);
        sc_valid = 1'b0;
        checkOutput("rom_ce_n1", rom_ce, lookup);
        checkOutput("ovr_quiet", ovr, 0);
        if (lookup) begin
            checkOutput("rom_ad_n1", rom_ad, b[6:0]);
            checkOutput("sc_ready_busy", sc_ready, 0);
            @(negedge clk);
            checkOutput("rom_ce_n2", rom_ce, 0);
            checkOutput("key_valid_n2", key_valid, 0);
            @(negedge clk);
            checkOutput("key_valid_n3", key_valid, expc != 7'd0);
            if (expc != 7'd0) begin
                checkOutput("key_ascii", key_ascii, expc);
                for (int i = 0; i < hold; i++) begin
                    @(negedge clk);
                    checkOutput("hold_valid", key_valid, 1);
                    checkOutput("hold_ascii", key_ascii, expc);
                    checkOutput("hold_sc_ready", sc_ready, 0);
                    if (hold >= 4 && i == 1) begin
                        sc_data = 8'($urandom_range(0, 255));
                        sc_valid = 1'b1;
                    end
                    if (hold >= 4 && i == 2) begin
                        checkOutput("ovr_pulse", ovr, 1);
                        sc_valid = 1'b0;
                    end
                    if (hold >= 4 && i == 3) checkOutput("ovr_single", ovr, 0);
                end
                key_ready = 1'b1;
                @(negedge clk);
            end
            checkOutput("key_valid_done", key_valid, 0);
        end
        checkOutput("sc_ready_idle", sc_ready, 1);
        checkOutput("shift_st", shift_st, m_lshift || m_rshift);
        checkOutput("caps_st", caps_st, m_caps);
    endtask

    initial begin
        int r;
        logic [7:0] b;
        int hold;

        for (int i = 0; i < 128; i++) begin
            if ($urandom_range(0, 3) == 0) rom_mem[i] = 14'd0;
            else rom_mem[i] = {7'($urandom_range(32, 126)), 7'($urandom_range(32, 126))};
        end
        rom_mem[7'h1C] = {7'h41, 7'h61};
        rom_mem[7'h16] = {7'h21, 7'h31};
        modelReset();

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_sc_ready", sc_ready, 1);
        checkOutput("rst_rom_ad", rom_ad, 0);
        checkOutput("rst_rom_ce", rom_ce, 0);
        checkOutput("rst_key_ascii", key_ascii, 0);
        checkOutput("rst_key_valid", key_valid, 0);
        checkOutput("rst_shift", shift_st, 0);
        checkOutput("rst_caps", caps_st, 0);
        checkOutput("rst_ovr", ovr, 0);
        reset = 1'b1;
        @(negedge clk);

        // Plain make code, then its break sequence
        applyStimulus(8'h1C, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h1C, 0);

        // Shift press / release around a letter
        applyStimulus(8'h12, 0);
        applyStimulus(8'h1C, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h12, 0);
        applyStimulus(8'h1C, 0);

        // Caps Lock toggle, letters vs digits
        applyStimulus(8'h58, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h58, 0);
        applyStimulus(8'h1C, 0);
        applyStimulus(8'h16, 0);

        // Caps plus Shift, extended code, high-bit byte
        applyStimulus(8'h59, 0);
        applyStimulus(8'h1C, 0);
        applyStimulus(8'hE0, 0);
        applyStimulus(8'h75, 0);
        applyStimulus(8'h83, 0);

        // Downstream stall with a dropped byte in the middle
        applyStimulus(8'h1C, 10);

        // Reset while a lookup is in flight
        @(negedge clk);
        sc_data = 8'h1C;
        sc_valid = 1'b1;
        @(negedge clk);
        sc_valid = 1'b0;
        checkOutput("pre_rst_rom_ce", rom_ce, 1);
        reset = 1'b0;
        #1;
        checkOutput("midrst_key_valid", key_valid, 0);
        checkOutput("midrst_sc_ready", sc_ready, 1);
        checkOutput("midrst_shift", shift_st, 0);
        checkOutput("midrst_caps", caps_st, 0);
        checkOutput("midrst_rom_ce", rom_ce, 0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(8'h1C, 0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'h12;
                3: b = 8'h59;
                4: b = 8'h58;
                5: b = 8'($urandom_range(128, 255));
                default: b = 8'($urandom_range(0, 127));
            endcase
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            applyStimulus(b, hold);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
